// File: rtl/price_delta_unit.sv
// Per-channel price delta stage: splits each price step into gain and loss magnitudes
// against the previous sample of the same channel, behind a single valid/ready output register.
module price_delta_unit #(
    parameter int G_WIDTH    = 16,
    parameter int G_CHANNELS = 4,
    localparam int CW        = (G_CHANNELS > 1) ? $clog2(G_CHANNELS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [CW-1:0]      i_ch,
    input  logic [G_WIDTH-1:0] i_price,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [CW-1:0]      o_ch,
    output logic [G_WIDTH-1:0] o_gain,
    output logic [G_WIDTH-1:0] o_loss,
    output logic               o_drop
);

    localparam logic [CW:0] CH_LIMIT = (CW+1)'(G_CHANNELS);

    logic [G_WIDTH-1:0] prev_q   [G_CHANNELS];
    logic               primed_q [G_CHANNELS];

    logic               accept;
    logic               ch_ok;
    logic               do_result;
    logic [G_WIDTH-1:0] prev_sel;
    logic               primed_sel;
    logic [G_WIDTH-1:0] gain_d;
    logic [G_WIDTH-1:0] loss_d;

    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;
    assign ch_ok   = ({1'b0, i_ch} < CH_LIMIT);

    // Channel select by compare rather than array index keeps out-of-range ids harmless.
    always_comb begin
        prev_sel   = '0;
        primed_sel = 1'b0;
        for (int c = 0; c < G_CHANNELS; c++) begin
            if (i_ch == CW'(c)) begin
                prev_sel   = prev_q[c];
                primed_sel = primed_q[c];
            end
        end
    end

    // Larger-minus-smaller in both directions, so neither side can wrap.
    always_comb begin
        gain_d = '0;
        loss_d = '0;
        if (i_price > prev_sel) begin
            gain_d = i_price - prev_sel;
        end else begin
            loss_d = prev_sel - i_price;
        end
    end

    // A concurrent clear turns the accepted sample into a priming sample.
    assign do_result = accept && ch_ok && primed_sel && !i_clear;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_ch    <= '0;
            o_gain  <= '0;
            o_loss  <= '0;
            o_drop  <= 1'b0;
        end else begin
            o_drop <= accept && !ch_ok;
            if (do_result) begin
                o_valid <= 1'b1;
                o_ch    <= i_ch;
                o_gain  <= gain_d;
                o_loss  <= loss_d;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < G_CHANNELS; c++) begin
                prev_q[c]   <= '0;
                primed_q[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < G_CHANNELS; c++) begin
                if (i_clear) begin
                    primed_q[c] <= 1'b0;
                end
                if (accept && ch_ok && (i_ch == CW'(c))) begin
                    prev_q[c]   <= i_price;
                    primed_q[c] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_price_delta_unit.sv
// Directed bench for price_delta_unit with three channels, so channel id 3 exercises the drop path.
module tb_price_delta_unit;

    localparam int W  = 16;
    localparam int NC = 3;
    localparam int CW = 2;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_clear;
    logic          i_valid;
    logic          o_ready;
    logic [CW-1:0] i_ch;
    logic [W-1:0]  i_price;
    logic          o_valid;
    logic          i_ready;
    logic [CW-1:0] o_ch;
    logic [W-1:0]  o_gain;
    logic [W-1:0]  o_loss;
    logic          o_drop;

    int n_checks = 0;
    int n_fail   = 0;

    price_delta_unit #(.G_WIDTH(W), .G_CHANNELS(NC)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_ch    (i_ch),
        .i_price (i_price),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_ch    (o_ch),
        .o_gain  (o_gain),
        .o_loss  (o_loss),
        .o_drop  (o_drop)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [CW-1:0] ch, input logic [W-1:0] price);
        i_valid = 1'b1;
        i_ch    = ch;
        i_price = price;
        step();
        i_valid = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [CW-1:0] ch,
                           input logic [W-1:0] gain, input logic [W-1:0] loss);
        chk({tag, ".valid"}, 32'(o_valid), 32'd1);
        chk({tag, ".ch"},    32'(o_ch),    32'(ch));
        chk({tag, ".gain"},  32'(o_gain),  32'(gain));
        chk({tag, ".loss"},  32'(o_loss),  32'(loss));
    endtask

    initial begin
        i_rst   = 1'b1;
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_ch    = '0;
        i_price = '0;
        i_ready = 1'b1;
        step();
        step();
        i_rst = 1'b0;

        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.ch",    32'(o_ch),    32'd0);
        chk("rst.gain",  32'(o_gain),  32'd0);
        chk("rst.loss",  32'(o_loss),  32'd0);
        chk("rst.drop",  32'(o_drop),  32'd0);
        chk("rst.ready", 32'(o_ready), 32'd1);

        // basic gain on ch0
        send(0, 16'h0A00);
        chk("prime0.valid", 32'(o_valid), 32'd0);
        send(0, 16'h0C80);
        chk_res("gain0", 0, 16'h0280, 16'h0000);

        // interleaved ch1 loss / ch2 equal
        send(1, 16'h1000);
        chk("prime1.valid", 32'(o_valid), 32'd0);
        send(2, 16'h0500);
        chk("prime2.valid", 32'(o_valid), 32'd0);
        send(1, 16'h0E00);
        chk_res("loss1", 1, 16'h0000, 16'h0200);
        send(2, 16'h0500);
        chk_res("eq2", 2, 16'h0000, 16'h0000);
        step();
        chk("idle.valid", 32'(o_valid), 32'd0);

        // stall: result held for 3 cycles, next sample waits at the input
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_ch    = 0;
        i_price = 16'h0D00;
        step();
        chk_res("stall.first", 0, 16'h0080, 16'h0000);
        i_ch    = 1;
        i_price = 16'h0F00;
        for (int k = 0; k < 3; k++) begin
            chk("stall.ready", 32'(o_ready), 32'd0);
            step();
            chk_res("stall.hold", 0, 16'h0080, 16'h0000);
        end
        i_ready = 1'b1;
        #1;
        chk("unstall.ready", 32'(o_ready), 32'd1);
        step();
        chk_res("flow.ch1", 1, 16'h0100, 16'h0000);
        i_ch    = 2;
        i_price = 16'h0400;
        step();
        chk_res("flow.ch2", 2, 16'h0000, 16'h0100);
        i_ch    = 0;
        i_price = 16'h0D00;
        step();
        chk_res("flow.ch0eq", 0, 16'h0000, 16'h0000);
        i_valid = 1'b0;
        step();
        chk("flow.drain", 32'(o_valid), 32'd0);

        // clear pulse forces re-prime
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        send(0, 16'h2000);
        chk("clr.reprime", 32'(o_valid), 32'd0);
        send(0, 16'h1F00);
        chk_res("clr.loss", 0, 16'h0000, 16'h0100);

        // clear coincident with accept: sample only primes
        i_clear = 1'b1;
        send(0, 16'h3000);
        i_clear = 1'b0;
        chk("clracc.valid", 32'(o_valid), 32'd0);
        send(0, 16'h3100);
        chk_res("clracc.next", 0, 16'h0100, 16'h0000);

        // clear does not flush a pending result
        step();
        i_ready = 1'b0;
        send(0, 16'h3000);
        chk_res("clrhold.res", 0, 16'h0000, 16'h0100);
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        chk_res("clrhold.kept", 0, 16'h0000, 16'h0100);
        i_ready = 1'b1;
        step();
        chk("clrhold.drain", 32'(o_valid), 32'd0);

        // out-of-range channel is dropped without touching history
        send(0, 16'h3000);
        chk("drop.prime0", 32'(o_valid), 32'd0);
        send(1, 16'h1000);
        send(2, 16'h2000);
        send(3, 16'h7777);
        chk("drop.pulse", 32'(o_drop),  32'd1);
        chk("drop.valid", 32'(o_valid), 32'd0);
        step();
        chk("drop.end",   32'(o_drop),  32'd0);
        send(0, 16'h3010);
        chk_res("drop.ch0", 0, 16'h0010, 16'h0000);
        send(1, 16'h0F00);
        chk_res("drop.ch1", 1, 16'h0000, 16'h0100);
        send(2, 16'h2000);
        chk_res("drop.ch2", 2, 16'h0000, 16'h0000);

        // reset while a result is stalled
        step();
        i_ready = 1'b0;
        send(0, 16'h3020);
        chk_res("rstmid.res", 0, 16'h0010, 16'h0000);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("rstmid.valid", 32'(o_valid), 32'd0);
        chk("rstmid.gain",  32'(o_gain),  32'd0);
        i_ready = 1'b1;
        send(0, 16'h4000);
        chk("rstmid.prime0", 32'(o_valid), 32'd0);
        send(1, 16'h0100);
        chk("rstmid.prime1", 32'(o_valid), 32'd0);
        send(0, 16'h4100);
        chk_res("rstmid.next", 0, 16'h0100, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
